// File: rtl/world_clock_pkg.sv
// Shared constants, zone offset table, day-offset codes and the 12-hour
// display mapping for the world clock.
package world_clock_pkg;

  localparam int KST_UTC_MIN = 540;
  localparam int MIN_PER_DAY = 1440;

  // Signed 15-minute units from UTC; element 0 is Seoul, element 7 Auckland.
  localparam logic [7:0][6:0] TZ_OFFSET = {
    7'sd48, -7'sd32, 7'sd38, 7'sd22, 7'sd0, -7'sd20, 7'sd4, 7'sd36
  };

  typedef enum logic [1:0] {
    DAY_SAME = 2'b00,
    DAY_NEXT = 2'b01,
    DAY_PREV = 2'b11
  } day_off_e;

  function automatic logic [4:0] to_12h(input logic [4:0] hour24);
    if (hour24 == 5'd0)       return 5'd12;
    else if (hour24 > 5'd12)  return hour24 - 5'd12;
    else                      return hour24;
  endfunction

endpackage

// File: rtl/tz_convert_pipe.sv
// Two-stage KST-to-zone conversion: stage 1 forms zone minutes-of-day
// (possibly out of range), stage 2 folds into one day and splits hour/min.
module tz_convert_pipe
  import world_clock_pkg::*;
#(
  parameter int TZ_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      kst_hour,
  input  logic [5:0]      kst_min,
  input  logic [5:0]      kst_sec,
  input  logic [TZ_W-1:0] tz_idx,
  input  logic            mode12,
  output logic [4:0]      disp_hour,
  output logic [5:0]      disp_min,
  output logic [5:0]      disp_sec,
  output logic            pm,
  output logic [1:0]      day_off
);

  logic signed [6:0]  off;
  logic signed [12:0] m_c;
  logic signed [12:0] s1_m;
  logic [5:0]         s1_sec;
  logic               s1_mode12;

  // 13-bit modular arithmetic yields the correct two's-complement result.
  always_comb begin
    off = $signed(TZ_OFFSET[3'(tz_idx)]);
    m_c = 13'(kst_hour) * 13'd60 + 13'(kst_min) - 13'(KST_UTC_MIN)
        + 13'(off) * 13'd15;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_m      <= '0;
      s1_sec    <= '0;
      s1_mode12 <= 1'b0;
    end else begin
      s1_m      <= m_c;
      s1_sec    <= kst_sec;
      s1_mode12 <= mode12;
    end
  end

  logic signed [12:0] m_wrap;
  day_off_e           day_c;
  logic [10:0]        m_day;
  logic [4:0]         hour_c;
  logic [5:0]         min_c;

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    m_wrap = s1_m;
    day_c  = DAY_SAME;
    if (s1_m < 13'sd0) begin
      m_wrap = s1_m + 13'(MIN_PER_DAY);
      day_c  = DAY_PREV;
    end else if (s1_m >= 13'(MIN_PER_DAY)) begin
      m_wrap = s1_m - 13'(MIN_PER_DAY);
      day_c  = DAY_NEXT;
    end
    m_day  = 11'(m_wrap);
    hour_c = 5'(m_day / 11'd60);
    min_c  = 6'(m_day % 11'd60);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_hour <= '0;
      disp_min  <= '0;
      disp_sec  <= '0;
      pm        <= 1'b0;
      day_off   <= DAY_SAME;
    end else begin
      disp_hour <= s1_mode12 ? to_12h(hour_c) : hour_c;
      disp_min  <= min_c;
      disp_sec  <= s1_sec;
      pm        <= (hour_c >= 5'd12);
      day_off   <= day_c;
    end
  end

endmodule

// File: rtl/world_clock_tz.sv
// KST wall clock with one-second prescaler, time-set and zone select,
// feeding the zone conversion pipeline.
module world_clock_tz
  import world_clock_pkg::*;
#(
  parameter int NUM_TZ   = 4,
  parameter int TZ_W     = 3,
  parameter int TICK_DIV = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [4:0]      set_hour,
  input  logic [5:0]      set_min,
  input  logic            tz_next,
  input  logic            mode12,
  output logic [TZ_W-1:0] tz_idx,
  output logic [4:0]      disp_hour,
  output logic [5:0]      disp_min,
  output logic [5:0]      disp_sec,
  output logic            pm,
  output logic [1:0]      day_off,
  output logic            sec_pulse
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] presc;
  logic [4:0]       kst_hour;
  logic [5:0]       kst_min;
  logic [5:0]       kst_sec;
  logic             tick;
  logic             set_ok;

  assign tick   = (presc == CNT_W'(TICK_DIV - 1));
  assign set_ok = set_en && (set_hour <= 5'd23) && (set_min <= 6'd59);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      kst_hour  <= '0;
      kst_min   <= '0;
      kst_sec   <= '0;
      tz_idx    <= '0;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= tick;

      if (tz_next)
        tz_idx <= (tz_idx == TZ_W'(NUM_TZ - 1)) ? '0 : tz_idx + TZ_W'(1);

      // A valid load wins over a same-cycle tick; an invalid one is ignored.
      if (set_ok) begin
        kst_hour <= set_hour;
        kst_min  <= set_min;
        kst_sec  <= '0;
        presc    <= '0;
      end else begin
        presc <= tick ? '0 : presc + CNT_W'(1);
        if (tick) begin
          if (kst_sec == 6'd59) begin
            kst_sec <= '0;
            if (kst_min == 6'd59) begin
              kst_min  <= '0;
              kst_hour <= (kst_hour == 5'd23) ? '0 : kst_hour + 5'd1;
            end else begin
              kst_min <= kst_min + 6'd1;
            end
          end else begin
            kst_sec <= kst_sec + 6'd1;
          end
        end
      end
    end
  end

  tz_convert_pipe #(.TZ_W(TZ_W)) u_conv (
    .clk      (clk),
    .rst      (rst),
    .kst_hour (kst_hour),
    .kst_min  (kst_min),
    .kst_sec  (kst_sec),
    .tz_idx   (tz_idx),
    .mode12   (mode12),
    .disp_hour(disp_hour),
    .disp_min (disp_min),
    .disp_sec (disp_sec),
    .pm       (pm),
    .day_off  (day_off)
  );

endmodule

// File: tb/tb_world_clock_tz.sv
// Bench for world_clock_tz: two instances (4 and 8 zones) share stimulus and
// are compared every cycle against a seconds-of-day reference model.
module tb_world_clock_tz;

  localparam int TICK_DIV = 4;
  localparam int TZ_W     = 3;

  int ntz[2]  = '{4, 8};
  int offs[8] = '{36, 4, -20, 0, 22, 38, -32, 48};

  logic       clk = 1'b0;
  logic       rst, set_en, tz_next, mode12;
  logic [4:0] set_hour;
  logic [5:0] set_min;

  logic [TZ_W-1:0] tz_a, tz_b;
  logic [4:0]      hr_a, hr_b;
  logic [5:0]      mn_a, mn_b, sc_a, sc_b;
  logic            pm_a, pm_b, sp_a, sp_b;
  logic [1:0]      do_a, do_b;

  always #5 clk = ~clk;

  world_clock_tz #(.NUM_TZ(4), .TZ_W(TZ_W), .TICK_DIV(TICK_DIV)) dut_a (
    .clk(clk), .rst(rst), .set_en(set_en), .set_hour(set_hour),
    .set_min(set_min), .tz_next(tz_next), .mode12(mode12), .tz_idx(tz_a),
    .disp_hour(hr_a), .disp_min(mn_a), .disp_sec(sc_a), .pm(pm_a),
    .day_off(do_a), .sec_pulse(sp_a)
  );

  world_clock_tz #(.NUM_TZ(8), .TZ_W(TZ_W), .TICK_DIV(TICK_DIV)) dut_b (
    .clk(clk), .rst(rst), .set_en(set_en), .set_hour(set_hour),
    .set_min(set_min), .tz_next(tz_next), .mode12(mode12), .tz_idx(tz_b),
    .disp_hour(hr_b), .disp_min(mn_b), .disp_sec(sc_b), .pm(pm_b),
    .day_off(do_b), .sec_pulse(sp_b)
  );

  typedef struct {
    int hour;
    int min;
    int sec;
    int pm;
    int day;
  } disp_t;

  // Reference state: KST as seconds of the day, prescaler phase, zone per
  // instance, and the two display values in flight.
  int    kst, presc, exp_pulse;
  int    tz[2];
  disp_t s1[2], out[2];
  bit    cur_m12;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic disp_t zone_view(input int kst_s, input int zone, input bit m12);
    disp_t d;
    int m, hr;
    m     = kst_s / 60 - 540 + offs[zone] * 15;
    d.day = (m < 0) ? 3 : (m >= 1440) ? 1 : 0;
    m     = (m + 1440) % 1440;
    hr    = m / 60;
    d.min = m % 60;
    d.sec = kst_s % 60;
    d.pm  = (hr >= 12) ? 1 : 0;
    d.hour = m12 ? ((hr % 12 == 0) ? 12 : hr % 12) : hr;
    return d;
  endfunction

  function automatic disp_t zero_disp();
    disp_t d;
    d.hour = 0; d.min = 0; d.sec = 0; d.pm = 0; d.day = 0;
    return d;
  endfunction

  task automatic model_edge(input bit r, input bit se, input int sh, input int sm,
                            input bit tn, input bit m12);
    bit tick;
    if (r) begin
      kst = 0; presc = 0; exp_pulse = 0;
      for (int k = 0; k < 2; k++) begin
        tz[k] = 0; s1[k] = zero_disp(); out[k] = zero_disp();
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        out[k] = s1[k];
        s1[k]  = zone_view(kst, tz[k], m12);
      end
      tick      = (presc == TICK_DIV - 1);
      exp_pulse = tick;
      if (se && sh <= 23 && sm <= 59) begin
        kst   = sh * 3600 + sm * 60;
        presc = 0;
      end else begin
        if (tick) kst = (kst + 1) % 86400;
        presc = (presc + 1) % TICK_DIV;
      end
      if (tn)
        for (int k = 0; k < 2; k++) tz[k] = (tz[k] + 1) % ntz[k];
    end
  endtask

  task automatic compare_all();
    check("a.tz_idx", tz_a, tz[0]);
    check("a.hour",   hr_a, out[0].hour);
    check("a.min",    mn_a, out[0].min);
    check("a.sec",    sc_a, out[0].sec);
    check("a.pm",     pm_a, out[0].pm);
    check("a.day",    do_a, out[0].day);
    check("a.pulse",  sp_a, exp_pulse);
    check("b.tz_idx", tz_b, tz[1]);
    check("b.hour",   hr_b, out[1].hour);
    check("b.min",    mn_b, out[1].min);
    check("b.sec",    sc_b, out[1].sec);
    check("b.pm",     pm_b, out[1].pm);
    check("b.day",    do_b, out[1].day);
    check("b.pulse",  sp_b, exp_pulse);
  endtask

  task automatic step(input bit r, input bit se, input int sh, input int sm,
                      input bit tn, input bit m12);
    rst      = r;
    set_en   = se;
    set_hour = 5'(sh);
    set_min  = 6'(sm);
    tz_next  = tn;
    mode12   = m12;
    @(posedge clk);
    model_edge(r, se, sh, sm, tn, m12);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, cur_m12);
  endtask

  task automatic set_time(input int h, input int m);
    step(1'b0, 1'b1, h, m, 1'b0, cur_m12);
  endtask

  task automatic select_tz(input int k, input int target);
    for (int i = 0; i < 16 && tz[k] != target; i++) begin
      step(1'b0, 1'b0, 0, 0, 1'b1, cur_m12);
      idle(1);
    end
    check("select_tz", tz[k], target);
  endtask

  task automatic wait_tick_phase();
    for (int i = 0; i < 2 * TICK_DIV && presc != TICK_DIV - 1; i++) idle(1);
    check("tick_phase", presc, TICK_DIV - 1);
  endtask

  task automatic check_zero();
    check("rst.a.hour", hr_a, 0);  check("rst.a.min", mn_a, 0);
    check("rst.a.sec",  sc_a, 0);  check("rst.a.pm",  pm_a, 0);
    check("rst.a.day",  do_a, 0);  check("rst.a.pulse", sp_a, 0);
    check("rst.a.tz",   tz_a, 0);  check("rst.b.hour", hr_b, 0);
    check("rst.b.sec",  sc_b, 0);  check("rst.b.tz",   tz_b, 0);
  endtask

  int pulses;
  int tz_seq[5] = '{1, 2, 3, 0, 1};

  initial begin
    cur_m12 = 1'b0;
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    check_zero();

    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      pulses += int'(sp_a);
    end
    check("pulse_count", pulses, 3);

    // Midnight rollover at Seoul, then the same at UTC.
    set_time(23, 59);
    idle(250);
    check("seoul.hour", hr_a, 0);
    check("seoul.min",  mn_a, 0);
    check("seoul.day",  do_a, 0);
    select_tz(0, 3);
    set_time(23, 59);
    idle(250);
    check("utc.hour", hr_a, 15);
    check("utc.min",  mn_a, 0);
    check("utc.b.hour", hr_b, 15);

    select_tz(0, 2);
    set_time(3, 10);
    idle(4);
    check("ny.hour", hr_a, 13);
    check("ny.min",  mn_a, 10);
    check("ny.pm",   pm_a, 1);
    check("ny.day",  do_a, 3);
    cur_m12 = 1'b1;
    idle(3);
    check("ny12.hour", hr_a, 1);
    check("ny12.pm",   pm_a, 1);
    cur_m12 = 1'b0;

    select_tz(1, 5);
    set_time(23, 45);
    idle(4);
    check("adl.hour", hr_b, 0);
    check("adl.min",  mn_b, 15);
    check("adl.day",  do_b, 1);
    select_tz(1, 4);
    set_time(23, 50);
    idle(4);
    check("kol.hour", hr_b, 20);
    check("kol.min",  mn_b, 20);
    check("kol.day",  do_b, 0);

    // Reset in mid-pipeline, then zone wrap on the 4-zone instance.
    set_time(7, 7);
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    check_zero();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 0, 0, 1'b1, cur_m12);
      check("tz_wrap", tz_a, tz_seq[i]);
    end

    wait_tick_phase();
    step(1'b0, 1'b0, 0, 0, 1'b1, cur_m12);
    check("tick_tz.tz",    tz_a, 2);
    check("tick_tz.pulse", sp_a, 1);

    idle(3);
    step(1'b0, 1'b1, 24, 30, 1'b0, cur_m12);
    idle(6);
    step(1'b0, 1'b1, 10, 60, 1'b0, cur_m12);
    idle(6);

    wait_tick_phase();
    set_time(12, 34);
    idle(2);
    check("set_tick.sec", sc_a, 0);
    check("set_tick.min", mn_a, 34);

    idle(5);
    step(1'b1, 1'b0, 0, 0, 1'b0, cur_m12);
    check_zero();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) cur_m12 = ~cur_m12;
      step($urandom_range(199) == 0, $urandom_range(29) == 0,
           int'($urandom_range(25)), int'($urandom_range(63)),
           $urandom_range(9) == 0, cur_m12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
